// File: rtl/fifo_tx_pkg.sv
// ---------------------------------------------------------------------------
// fifo_tx_pkg
// Shared definitions for the FIFO-fed serial byte transmitter.
//   tx_state_e        : FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   DEF_CLKS_PER_BIT  : default clock cycles per serial bit
//   DEF_PARITY_EN     : default parity enable (0 = no parity bit)
//   even_parity()     : XOR reduction of a data byte
// ---------------------------------------------------------------------------
package fifo_tx_pkg;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_PARITY_EN    = 0;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_e;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// ---------------------------------------------------------------------------
// tx_bit_timer
// Bit-period counter. Counts 0 .. CLKS_PER_BIT-1 and wraps, flagging the
// final cycle of each bit period with bit_end.
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset, clears the count
//   clear   : restart the bit period on the next edge (used on state entry)
//   bit_end : high in the last cycle of the current bit period
// ---------------------------------------------------------------------------
module tx_bit_timer #(
  parameter int CLKS_PER_BIT = 16,
  localparam int CW = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end
);

  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  assign bit_end = (count == LAST);

  // Wrapping on bit_end and clearing coincide at state changes driven by
  // bit_end; clear only matters when a state is entered mid-period
  // (leaving IDLE, where the counter is parked at zero).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || bit_end) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_byte_tx.sv
// ---------------------------------------------------------------------------
// fifo_byte_tx
// Pops bytes from a show-ahead FIFO and sends each as an asynchronous serial
// frame: start bit (0), 8 data bits LSB first, optional even parity bit,
// stop bit (1). Back-to-back frames run with no idle gap.
//
// Handshake: fifo_data is valid combinationally for the current read
// pointer whenever fifo_empty=0. fifo_rd is a one-cycle pop strobe; the
// byte is consumed (latched here and popped in the FIFO) on the rising edge
// where fifo_rd is high. fifo_rd is never raised while fifo_empty=1 or while
// rst_n=0.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : synchronous reset, active-low
//   tx_en      : permission to start new frames
//   fifo_empty : FIFO empty flag
//   fifo_data  : FIFO read data (8 bits)
//   fifo_rd    : pop strobe to the FIFO
//   tx_line    : serial output, idle high
//   tx_busy    : high while a frame is in progress
//   frame_done : one-cycle pulse in the final cycle of the stop bit
//   fsm_state  : current FSM state, for observation
// ---------------------------------------------------------------------------
module fifo_byte_tx
  import fifo_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int PARITY_EN    = DEF_PARITY_EN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tx_en,
  input  logic            fifo_empty,
  input  logic [7:0]      fifo_data,
  output logic            fifo_rd,
  output logic            tx_line,
  output logic            tx_busy,
  output logic            frame_done,
  output tx_state_e       fsm_state
);

  tx_state_e state;
  tx_state_e state_next;

  logic       bit_end;
  logic       timer_clear;
  logic       can_pop;
  logic       pop;

  logic [7:0] shreg;
  logic [2:0] bit_idx;
  logic       par_bit;

  assign fsm_state = state;

  // ------------------------------------------------------------------
  // Bit-period timer. Parked at zero in IDLE and restarted whenever the
  // FSM changes state, so every state begins a fresh bit period.
  // ------------------------------------------------------------------
  assign timer_clear = (state == S_IDLE) || (state_next != state);

  tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .bit_end(bit_end)
  );

  // ------------------------------------------------------------------
  // Pop decision. A new frame may start from IDLE, or from the final
  // STOP cycle so the next START follows with no gap. rst_n gates the
  // strobe so no pop can happen during a reset cycle.
  // ------------------------------------------------------------------
  assign can_pop = rst_n && tx_en && !fifo_empty;

  always_comb begin
    pop = 1'b0;
    if (can_pop) begin
      if (state == S_IDLE) begin
        pop = 1'b1;
      end else if (state == S_STOP && bit_end) begin
        pop = 1'b1;
      end
    end
  end

  assign fifo_rd = pop;

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (pop) state_next = S_START;
      end
      S_START: begin
        if (bit_end) state_next = S_DATA;
      end
      S_DATA: begin
        if (bit_end && bit_idx == 3'd7) begin
          state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_end) state_next = S_STOP;
      end
      S_STOP: begin
        if (bit_end) state_next = pop ? S_START : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: outputs
  // ------------------------------------------------------------------
  always_comb begin
    tx_line    = 1'b1;
    tx_busy    = (state != S_IDLE);
    frame_done = 1'b0;
    unique case (state)
      S_IDLE:   tx_line = 1'b1;
      S_START:  tx_line = 1'b0;
      S_DATA:   tx_line = shreg[0];
      S_PARITY: tx_line = par_bit;
      S_STOP: begin
        tx_line    = 1'b1;
        frame_done = bit_end;
      end
      default:  tx_line = 1'b1;
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath: shift register, bit index and parity.
  // The byte and its parity are captured only on the pop edge, so
  // fifo_data is ignored at all other times. Parity is computed from the
  // latched byte before shifting destroys it.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_idx <= '0;
      par_bit <= 1'b0;
    end else if (pop) begin
      shreg   <= fifo_data;
      bit_idx <= '0;
      par_bit <= even_parity(fifo_data);
    end else if (state == S_DATA && bit_end) begin
      shreg   <= {1'b0, shreg[7:1]};
      // Wraps 7 -> 0 as the FSM leaves DATA.
      bit_idx <= bit_idx + 3'd1;
    end
  end

endmodule
